// File: rtl/clkdiv_meter.sv
// clkdiv_meter: measures the period and high time of a slow clock/pulse
// (sig_in) in system-clock cycles, and reports lock and timeout status.
//
// Ports:
//   clk       in   system clock, all logic on rising edge
//   resetq    in   asynchronous active-low reset
//   enable    in   measurement enable; low forces IDLE
//   sig_in    in   signal to measure, asynchronous to clk
//   period    out  [WIDTH]  last measured period (clk cycles)
//   high_time out  [WIDTH]  last measured high time (clk cycles)
//   valid     out  one-cycle strobe, period/high_time updated this cycle
//   locked    out  LOCK_COUNT consecutive periods matched within TOL
//   timeout   out  sticky, no rising edge within 2^WIDTH-1 cycles
module clkdiv_meter #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 0
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned MCW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [MCW-1:0]   MC_MAX  = MCW'(LOCK_COUNT);
  localparam logic [WIDTH:0]   TOL_W   = (WIDTH+1)'(TOL);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEAS = 2'd2} state_t;

  state_t state;
  state_t state_nxt;

  logic s1, s2, s3;
  logic rise_c, fall_c;

  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] hcnt, hcnt_nxt;
  logic [MCW-1:0]   mcnt, mcnt_nxt;
  logic             have_prev, have_prev_nxt;
  logic [WIDTH-1:0] period_nxt, high_time_nxt;
  logic             valid_nxt, locked_nxt, timeout_nxt;

  logic [WIDTH:0]   diff_c;
  logic             match_c;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;
  assign fall_c = ~s2 & s3;

  // Distance between the new period (cnt) and the previous one, no wrap
  assign diff_c  = (cnt >= period) ? ({1'b0, cnt} - {1'b0, period})
                                   : ({1'b0, period} - {1'b0, cnt});
  assign match_c = (diff_c <= TOL_W);

  // State register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a rise in the saturating cycle keeps us in MEAS
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (fall_c) state_nxt = ARM;
        ARM:     if (rise_c) state_nxt = MEAS;
        MEAS:    if (!rise_c && (cnt == CNT_MAX)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    cnt_nxt       = cnt;
    hcnt_nxt      = hcnt;
    mcnt_nxt      = mcnt;
    have_prev_nxt = have_prev;
    period_nxt    = period;
    high_time_nxt = high_time;
    valid_nxt     = 1'b0;
    locked_nxt    = locked;
    timeout_nxt   = timeout;

    if (!enable) begin
      cnt_nxt       = '0;
      hcnt_nxt      = '0;
      mcnt_nxt      = '0;
      have_prev_nxt = 1'b0;
      locked_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt       = '0;
          hcnt_nxt      = '0;
          have_prev_nxt = 1'b0;
        end
        ARM: begin
          if (rise_c) begin
            cnt_nxt  = WIDTH'(1);
            hcnt_nxt = WIDTH'(1);
          end
        end
        MEAS: begin
          if (rise_c) begin
            period_nxt    = cnt;
            high_time_nxt = hcnt;
            valid_nxt     = 1'b1;
            timeout_nxt   = 1'b0;
            cnt_nxt       = WIDTH'(1);
            hcnt_nxt      = WIDTH'(1);
            have_prev_nxt = 1'b1;
            // First strobe after entering MEAS only seeds the comparison
            if (have_prev && match_c) begin
              mcnt_nxt = (mcnt == MC_MAX) ? mcnt : (mcnt + MCW'(1));
            end else begin
              mcnt_nxt = '0;
            end
            locked_nxt = (mcnt_nxt == MC_MAX);
          end else if (cnt == CNT_MAX) begin
            timeout_nxt   = 1'b1;
            locked_nxt    = 1'b0;
            mcnt_nxt      = '0;
            cnt_nxt       = '0;
            hcnt_nxt      = '0;
            have_prev_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + WIDTH'(1);
            // hcnt <= cnt always, so this cannot overflow
            if (s2) hcnt_nxt = hcnt + WIDTH'(1);
          end
        end
        default: begin
          cnt_nxt  = '0;
          hcnt_nxt = '0;
        end
      endcase
    end
  end

  // Counter and output registers
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cnt       <= '0;
      hcnt      <= '0;
      mcnt      <= '0;
      have_prev <= 1'b0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      hcnt      <= hcnt_nxt;
      mcnt      <= mcnt_nxt;
      have_prev <= have_prev_nxt;
      period    <= period_nxt;
      high_time <= high_time_nxt;
      valid     <= valid_nxt;
      locked    <= locked_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule
